photodiode_capture_ctrl: RTL
============================

# photodiode_capture_ctrl

Measurement sequencer for the five-channel photodiode front end. It arms a capture, waits for all channels to go dark, then timestamps the ordered rising edges of PD[0]..PD[4] against a cycle counter started by PD[0]. It holds the four inter-channel delays in a valid/ready result register for the downstream readout logic. It also provides timeout, abort and auto-rearm so that software and the button path never have to sequence the delay datapath cycle by cycle.

## Interface
Parameters:
- CNT_W, 12, width of delay counter and of each delay field
- TIMEOUT, 4095, counter value at which a measurement is abandoned (must be ≤ 2^CNT_W−1)
- N_PD, 5, number of photodiode channels (fixed at 5 for this revision)

Ports:
- clk  in  1  system clock (100 MHz)
- rst  in  1  asynchronous, active-low reset (0 = reset)
- PD  in  5  raw asynchronous photodiode comparator outputs
- arm  in  1  single-cycle start request
- abort  in  1  single-cycle cancel request
- auto_rearm  in  1  re-enter ARMED after result is consumed
- res_ready  in  1  downstream accepts result
- res_valid  out  1  result held and valid
- res_delays  out  4*CNT_W  {d3,d2,d1,d0}; d(k) is the cycles from PD[0] to PD[k+1]
- res_timeout  out  1  result ended by timeout
- busy  out  1  state ≠ IDLE
- meas_count  out  16  completed handshakes, wraps
- state_o  out  3  current state encoding

## Operation
- PD passes through a 2-flop synchronizer and then a rising-edge detector (rise = sync & ~sync_d).
- IDLE: all counters are held. arm → ARMED. arm in any other state is ignored.
- ARMED: waits until the synchronized PD is 5'b00000 for at least one cycle, then sets dark_seen. After dark_seen, a rise on PD[0] → MEASURE, with cnt=0 and next=1.
- MEASURE:
  - cnt increments by 1 each cycle.
  - For each channel k ≥ next in ascending order whose rise is detected this cycle, with all channels between next and k also rising: d(k−1) ← cnt, and next advances past k.
  - A rise on a channel beyond a gap (out of order) is ignored.
  - When channel 4 is captured, go to DONE.
  - If cnt reaches TIMEOUT first: go to DONE with res_timeout=1 and uncaptured d fields set to all-ones.
- DONE: res_valid=1, and res_delays/res_timeout are stable. On res_valid & res_ready:
  - meas_count increments (wrapping).
  - The next state is ARMED (dark_seen cleared) if auto_rearm is 1, else IDLE.
- abort takes priority in every state: go to IDLE, res_valid=0, fields cleared. abort beats arm and the handshake in the same cycle.
- Multiple channels rising on the same cycle receive identical delay values. PD[0] and PD[1] rising together gives d0=0.
- cnt is CNT_W wide and never wraps. It is bounded by TIMEOUT.

## Timing
- Reset values: state IDLE, res_valid 0, res_delays 0, res_timeout 0, busy 0, meas_count 0, state_o 0, synchronizer flops 0.
- Pin-to-detect latency is 3 clk, identical on all channels, so it cancels in the delays. Accuracy is ±1 cycle due to synchronizer sampling.
- The PD[4] rise is detected in cycle n, and res_valid rises in cycle n+1.
- The handshake completes on the edge where res_valid & res_ready. res_valid falls the next cycle, and res_ready is not required to be low beforehand.
- Reset asserted mid-measurement clears everything immediately. No partial result is emitted after release.
- State encoding: IDLE=0, ARMED=1, MEASURE=2, DONE=3.

## Structure
- Package photodiode_pkg contains:
  - the state enum (IDLE, ARMED, MEASURE, DONE)
  - CNT_W_DEFAULT, N_PD, DELAY_SAT (all-ones)
  - a typedef for the packed delay array
- Submodule pd_sync_edge is parameterized on width. It holds the 2-flop synchronizer and the rising-edge detect, and is reusable by the button path.
- The top level contains the FSM, counter, capture registers and output register.

## Test plan
- Staggered edges: arm, PD all 0. Raise PD[0] at t, then PD[1..4] at t+400, +800, +1200, +1600 cycles, and keep res_ready high → res_delays={1600,1200,800,400}, res_timeout=0, meas_count=1.
- Simultaneous edges: PD[0] and PD[1] rise together, PD[2]=PD[3] at +100, PD[4] at +250 → d0=0, d1=d2=100, d3=250.
- Timeout: PD[0] rises and the other channels stay low → DONE after 4095 cycles, res_timeout=1, all d=0xFFF.
- Out of order and not dark: arm while PD=5'b11111 → stays ARMED until all are low. A PD[3] rise before PD[1],PD[2] is ignored and channel 3 is captured on its next valid rise.
- Backpressure with auto_rearm=1: res_ready held low for 50 cycles → res_valid and data stable. Raising res_ready → ARMED and meas_count increments. abort during MEASURE → IDLE, res_valid=0.
- Reset mid-MEASURE: assert rst low for 2 cycles → all outputs at reset values. A new arm produces a clean measurement.

Source files
------------

// File: rtl/photodiode_pkg.sv
// Shared types and constants for the photodiode capture sequencer.
package photodiode_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    MEASURE = 3'd2,
    DONE    = 3'd3
  } state_t;

  localparam int CNT_W_DEFAULT = 12;
  localparam int N_PD          = 5;
  localparam logic [CNT_W_DEFAULT-1:0] DELAY_SAT = '1;

  typedef logic [N_PD-2:0][CNT_W_DEFAULT-1:0] delay_arr_t;

endpackage

// File: rtl/pd_sync_edge.sv
// Two-flop synchronizer plus rising-edge detect for a bus of asynchronous inputs.
module pd_sync_edge #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] sync,
  output logic [W-1:0] rise
);

  logic [W-1:0] meta_reg;
  logic [W-1:0] sync_reg;
  logic [W-1:0] sync_d_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_reg   <= '0;
      sync_reg   <= '0;
      sync_d_reg <= '0;
    end else begin
      meta_reg   <= din;
      sync_reg   <= meta_reg;
      sync_d_reg <= sync_reg;
    end
  end

  assign sync = sync_reg;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_rise
      assign rise[gi] = sync_reg[gi] & ~sync_d_reg[gi];
    end
  endgenerate

endmodule

// File: rtl/photodiode_capture_ctrl.sv
// Arms a capture, waits for darkness, then timestamps ordered PD rises against a
// counter started by PD[0] and holds the delays in a valid/ready result register.
module photodiode_capture_ctrl #(
  parameter int CNT_W   = 12,
  parameter int TIMEOUT = 4095,
  parameter int N_PD    = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_PD-1:0]      PD,
  input  logic                 arm,
  input  logic                 abort,
  input  logic                 auto_rearm,
  input  logic                 res_ready,
  output logic                 res_valid,
  output logic [4*CNT_W-1:0]   res_delays,
  output logic                 res_timeout,
  output logic                 busy,
  output logic [15:0]          meas_count,
  output logic [2:0]           state_o
);
  import photodiode_pkg::*;

  logic [N_PD-1:0] pd_sync;
  logic [N_PD-1:0] pd_rise;

  pd_sync_edge #(.W(N_PD)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (PD),
    .sync (pd_sync),
    .rise (pd_rise)
  );

  state_t                     state_reg;
  logic [CNT_W-1:0]           cnt_reg;
  logic [2:0]                 next_reg;
  logic                       dark_seen_reg;
  logic                       res_valid_reg;
  logic                       res_timeout_reg;
  logic [N_PD-2:0][CNT_W-1:0] delays_reg;
  logic [15:0]                meas_count_reg;

  logic             start_hit;
  logic             cap_en;
  logic [CNT_W-1:0] cur_cnt;
  logic [2:0]       cur_next;
  logic [2:0]       next_next;
  logic [N_PD-1:0]  cap;
  logic             run;
  logic             done_hit;
  logic             timeout_hit;

  // The PD[0] detect cycle is time zero, so channels rising with PD[0] are
  // captured there with delay 0; MEASURE then starts the counter at 1.
  always_comb begin
    start_hit = (state_reg == ARMED) && dark_seen_reg && pd_rise[0];
    cap_en    = start_hit || (state_reg == MEASURE);
    cur_cnt   = (state_reg == MEASURE) ? cnt_reg : '0;
    cur_next  = (state_reg == MEASURE) ? next_reg : 3'd1;
    run       = cap_en;
    next_next = cur_next;
    cap       = '0;
    for (int k = 1; k < N_PD; k++) begin
      if (3'(k) >= cur_next) begin
        run    = run & pd_rise[k];
        cap[k] = run;
        if (run) next_next = 3'(k + 1);
      end
    end
    done_hit    = cap[N_PD-1];
    timeout_hit = (state_reg == MEASURE) && !done_hit && (cnt_reg == CNT_W'(TIMEOUT));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      next_reg        <= 3'd1;
      dark_seen_reg   <= 1'b0;
      res_valid_reg   <= 1'b0;
      res_timeout_reg <= 1'b0;
      delays_reg      <= '0;
      meas_count_reg  <= '0;
    end else if (abort) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      next_reg        <= 3'd1;
      dark_seen_reg   <= 1'b0;
      res_valid_reg   <= 1'b0;
      res_timeout_reg <= 1'b0;
      delays_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (arm) begin
            state_reg     <= ARMED;
            dark_seen_reg <= 1'b0;
          end
        end
        ARMED: begin
          if (pd_sync == '0) dark_seen_reg <= 1'b1;
          if (start_hit) begin
            cnt_reg         <= CNT_W'(1);
            next_reg        <= next_next;
            delays_reg      <= '0;
            res_timeout_reg <= 1'b0;
            dark_seen_reg   <= 1'b0;
            if (done_hit) begin
              state_reg     <= DONE;
              res_valid_reg <= 1'b1;
            end else begin
              state_reg     <= MEASURE;
            end
          end
        end
        MEASURE: begin
          next_reg <= next_next;
          if (cnt_reg != CNT_W'(TIMEOUT)) cnt_reg <= cnt_reg + 1'b1;
          if (done_hit) begin
            state_reg     <= DONE;
            res_valid_reg <= 1'b1;
          end else if (timeout_hit) begin
            state_reg       <= DONE;
            res_valid_reg   <= 1'b1;
            res_timeout_reg <= 1'b1;
            for (int k = 1; k < N_PD; k++) begin
              if (3'(k) >= next_next) delays_reg[k-1] <= '1;
            end
          end
        end
        DONE: begin
          if (res_ready) begin
            meas_count_reg <= meas_count_reg + 16'd1;
            res_valid_reg  <= 1'b0;
            dark_seen_reg  <= 1'b0;
            state_reg      <= auto_rearm ? ARMED : IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
      // Captures land after the case so they override the clear on MEASURE entry.
      for (int k = 1; k < N_PD; k++) begin
        if (cap[k]) delays_reg[k-1] <= cur_cnt;
      end
    end
  end

  assign res_valid   = res_valid_reg;
  assign res_delays  = delays_reg;
  assign res_timeout = res_timeout_reg;
  assign busy        = (state_reg != IDLE);
  assign meas_count  = meas_count_reg;
  assign state_o     = state_reg;

endmodule
